// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : Row-scanning 4x4 keypad controller. Drives one row low per
//               scan tick, accumulates a full frame of column samples, then
//               runs a frame-paced debounce FSM that emits one key_valid pulse
//               per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic            clk_12MHz,
    input  logic            rst,
    input  logic            scan_tick,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int              c_RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int              c_NK       = ROWS * COLS;
    localparam logic [3:0]      c_DEB      = 4'(DEBOUNCE);
    localparam bit              c_DEB_ONE  = (DEBOUNCE == 1);
    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_DEB_PRESS   = 2'd1,
        S_PRESSED     = 2'd2,
        S_DEB_RELEASE = 2'd3
    } state_t;

    logic [COLS-1:0] r_col_meta;
    logic [COLS-1:0] r_col_sync;
    logic [c_RW-1:0] r_row;
    logic [ROWS-1:0] r_row_out;
    logic [c_NK-1:0] r_acc;
    state_t          r_state;
    logic [3:0]      r_cand;
    logic [3:0]      r_cnt;
    logic [3:0]      r_key_code;
    logic            r_key_valid;

    logic            w_frame_end;
    logic [c_RW-1:0] w_row_next;
    logic [c_NK-1:0] w_sample;
    logic [c_NK-1:0] w_frame;
    logic            w_one;
    logic            w_many;
    logic            w_single;
    logic [3:0]      w_idx;
    logic [3:0]      w_cnt_inc;
    state_t          w_state_nxt;
    logic [3:0]      w_cand_nxt;
    logic [3:0]      w_cnt_nxt;
    logic [3:0]      w_code_nxt;
    logic            w_valid_nxt;

    // Two-flop synchronizer for the asynchronous, active-low column lines.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= col_in;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_frame_end = scan_tick && (r_row == c_LAST_ROW);
    assign w_row_next  = (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;

    // Place the current row's pressed columns into their frame positions.
    always_comb begin
        w_sample = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_row == c_RW'(r)) begin
                w_sample[r*COLS +: COLS] = ~r_col_sync;
            end
        end
    end

    assign w_frame = r_acc | w_sample;

    // Row pointer, row drive and frame accumulator advance once per tick.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            r_row     <= '0;
            r_row_out <= ~(ROWS'(1));
            r_acc     <= '0;
        end else if (scan_tick) begin
            r_row     <= w_row_next;
            r_row_out <= ~(ROWS'(1) << w_row_next);
            r_acc     <= w_frame_end ? '0 : w_frame;
        end
    end

    // Classify the completed frame: exactly one intersection low is SINGLE.
    always_comb begin
        w_one  = 1'b0;
        w_many = 1'b0;
        w_idx  = '0;
        for (int i = 0; i < c_NK; i++) begin
            if (w_frame[i]) begin
                if (w_one) begin
                    w_many = 1'b1;
                end
                w_one = 1'b1;
                w_idx = 4'(i);
            end
        end
    end

    assign w_single  = w_one && !w_many;
    assign w_cnt_inc = (r_cnt >= c_DEB) ? r_cnt : r_cnt + 4'd1;

    // Debounce next-state logic; only a frame-end tick can move the FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_idx;
                        w_cnt_nxt  = 4'd1;
                        if (c_DEB_ONE) begin
                            w_state_nxt = S_PRESSED;
                            w_code_nxt  = w_idx;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_DEB_PRESS;
                        end
                    end
                end
                S_DEB_PRESS: begin
                    if (w_single && (w_idx == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= c_DEB) begin
                            w_state_nxt = S_PRESSED;
                            w_code_nxt  = r_cand;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_idx;
                        w_cnt_nxt  = 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (!(w_single && (w_idx == r_cand))) begin
                        // With a one-frame debounce a single empty frame is a release.
                        if (!w_single && c_DEB_ONE) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_DEB_RELEASE;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                S_DEB_RELEASE: begin
                    if (w_single && (w_idx == r_cand)) begin
                        w_state_nxt = S_PRESSED;
                    end else if (w_single) begin
                        w_state_nxt = S_DEB_PRESS;
                        w_cand_nxt  = w_idx;
                        w_cnt_nxt   = 4'd1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= c_DEB) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Debounce state, candidate, counter and key outputs register together.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
        end
    end

    assign row_out   = r_row_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == S_PRESSED) || (r_state == S_DEB_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_ctrl
// Description : Self-checking bench for keypad_scan_ctrl. A keypad matrix
//               model drives col_in from row_out; a frame-history reference
//               model predicts row_out, key_valid, key_held and key_code.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DEB  = 4;
    localparam int NPH  = 16;

    logic            clk_12MHz = 1'b0;
    logic            rst       = 1'b1;
    logic            scan_tick = 1'b0;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;

    logic [15:0] keys = '0;
    int          n_err = 0;
    int          n_chk = 0;
    int          vcount = 0;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_valids;
        logic        exp_held;
        logic [3:0]  exp_code;
    } phase_t;

    phase_t tbl [NPH];

    // Reference model state: frame history and acceptance bookkeeping.
    int          m_tick;
    logic [15:0] m_acc;
    int          hist [$];
    int          m_arm;
    bit          m_held;
    int          m_code;
    int          m_nonh;
    bit          m_valid;

    keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEB)) dut (
        .clk_12MHz (clk_12MHz),
        .rst       (rst),
        .scan_tick (scan_tick),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!row_out[r] && keys[r*COLS + c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    // Count every cycle key_valid is high.
    always @(posedge clk_12MHz) begin
        if (key_valid === 1'b1) vcount <= vcount + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_tick  = 0;
        m_acc   = '0;
        hist.delete();
        m_arm   = 0;
        m_held  = 1'b0;
        m_code  = 0;
        m_nonh  = 0;
        m_valid = 1'b0;
    endtask

    // One tick of the reference: OR this row's keys into the frame; at the
    // last row, judge the frame and apply the acceptance/release rules.
    task automatic m_step(input logic [15:0] k);
        int row;
        int c;
        int last;
        bit same;
        row = m_tick % ROWS;
        m_acc = m_acc | (k & (16'hF << (row * COLS)));
        m_tick++;
        m_valid = 1'b0;
        if (row == ROWS - 1) begin
            c = -1;
            if ($countones(m_acc) == 1) begin
                for (int i = 0; i < 16; i++) if (m_acc[i]) c = i;
            end
            m_acc = '0;
            hist.push_back(c);
            last = hist.size() - 1;
            if (!m_held) begin
                // Accept when the last DEB eligible frames all show the same key.
                if (c >= 0 && (last - m_arm + 1) >= DEB) begin
                    same = 1'b1;
                    for (int j = last - DEB + 1; j <= last; j++) begin
                        if (hist[j] != c) same = 1'b0;
                    end
                    if (same) begin
                        m_held  = 1'b1;
                        m_code  = c;
                        m_nonh  = 0;
                        m_valid = 1'b1;
                    end
                end
            end else if (c == m_code) begin
                m_nonh = 0;
            end else begin
                m_nonh++;
                if (m_nonh >= 2 && c >= 0) begin
                    m_held = 1'b0;
                    m_arm  = last;
                end else if (m_nonh >= DEB) begin
                    m_held = 1'b0;
                    m_arm  = last + 1;
                end
            end
        end
    endtask

    // Settle 4 cycles, issue one tick, then compare against the model.
    task automatic do_tick();
        logic [15:0] k;
        repeat (4) begin @(posedge clk_12MHz); #1; end
        k = keys;
        scan_tick = 1'b1;
        @(posedge clk_12MHz); #1;
        scan_tick = 1'b0;
        m_step(k);
        check("row_out",   int'(row_out),   (~(1 << (m_tick % ROWS))) & 15);
        check("key_valid", int'(key_valid), int'(m_valid));
        check("key_held",  int'(key_held),  int'(m_held));
        check("key_code",  int'(key_code),  m_code);
    endtask

    task automatic do_reset(input bit with_tick);
        rst = 1'b1;
        scan_tick = with_tick;
        @(posedge clk_12MHz); #1;
        rst = 1'b0;
        scan_tick = 1'b0;
        m_reset();
        check("rst_row_out",   int'(row_out),   14);
        check("rst_key_code",  int'(key_code),  0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held",  int'(key_held),  0);
    endtask

    task automatic settle();
        repeat (2) begin @(posedge clk_12MHz); #1; end
    endtask

    initial begin
        int          v0;
        int          sel;
        int          len;
        logic [15:0] one;

        // Test-plan phases, each run on whole frames with the key pattern held.
        tbl[0]  = '{16'h0000, 2, 0, 1'b0, 4'd0};
        tbl[1]  = '{16'h0200, 6, 1, 1'b1, 4'd9};
        tbl[2]  = '{16'h0000, 3, 0, 1'b1, 4'd9};
        tbl[3]  = '{16'h0000, 1, 0, 1'b0, 4'd9};
        tbl[4]  = '{16'h0200, 2, 0, 1'b0, 4'd9};
        tbl[5]  = '{16'h0000, 1, 0, 1'b0, 4'd9};
        tbl[6]  = '{16'h0200, 3, 0, 1'b0, 4'd9};
        tbl[7]  = '{16'h0200, 1, 1, 1'b1, 4'd9};
        tbl[8]  = '{16'h0000, 4, 0, 1'b0, 4'd9};
        tbl[9]  = '{16'h8001, 8, 0, 1'b0, 4'd9};
        tbl[10] = '{16'h0000, 1, 0, 1'b0, 4'd9};
        tbl[11] = '{16'h0200, 4, 1, 1'b1, 4'd9};
        tbl[12] = '{16'h0000, 2, 0, 1'b1, 4'd9};
        tbl[13] = '{16'h0020, 1, 0, 1'b0, 4'd9};
        tbl[14] = '{16'h0020, 3, 1, 1'b1, 4'd5};
        tbl[15] = '{16'h0000, 4, 0, 1'b0, 4'd5};

        m_reset();
        #1;
        do_reset(1'b0);

        for (int p = 0; p < NPH; p++) begin
            v0 = vcount;
            keys = tbl[p].keys;
            for (int t = 0; t < tbl[p].frames * ROWS; t++) do_tick();
            settle();
            check($sformatf("phase%0d_valids", p), vcount - v0, tbl[p].exp_valids);
            check($sformatf("phase%0d_held", p), int'(key_held), int'(tbl[p].exp_held));
            check($sformatf("phase%0d_code", p), int'(key_code), int'(tbl[p].exp_code));
        end

        // Reset mid-frame during a debounce, with a tick coincident with rst.
        do_reset(1'b0);
        keys = 16'h0200;
        for (int t = 0; t < 3 * ROWS + 3; t++) do_tick();
        do_reset(1'b1);
        v0 = vcount;
        for (int t = 0; t < 3 * ROWS; t++) do_tick();
        settle();
        check("rst_resume_3frames_valids", vcount - v0, 0);
        for (int t = 0; t < ROWS; t++) do_tick();
        settle();
        check("rst_resume_4frames_valids", vcount - v0, 1);
        check("rst_resume_code", int'(key_code), 9);
        check("rst_resume_held", int'(key_held), 1);

        // Randomized key patterns, changed at arbitrary ticks.
        keys = '0;
        do_reset(1'b0);
        one = 16'd1;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      keys = '0;
            else if (sel < 8) keys = one << $urandom_range(0, 15);
            else              keys = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            len = int'($urandom_range(1, 24));
            for (int t = 0; t < len; t++) do_tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Row-scanning controller for the calculator's 4x4 keypad. It is paced by the 1 kHz single-cycle tick from the 12 MHz divider. It drives one keypad row low at a time, samples the column lines, and evaluates each full scan frame. A debounce state machine then issues exactly one key event per physical press to the calculator core.

## Interface
- ROWS, 4, number of keypad rows scanned; row_out width.
- COLS, 4, number of column inputs; col_in width.
- DEBOUNCE, 4, consecutive identical frames required to accept a press or a release; range 1..15.
- clk_12MHz  input  1  system clock, 12 MHz.
- rst  input  1  reset; one clock domain, synchronous, active-high.
- scan_tick  input  1  one-cycle pulse at 1 kHz from the 1000 Hz divider; advances the scan.
- col_in  input  COLS  keypad columns, active-low, asynchronous; 2-FF synchronized internally.
- row_out  output  ROWS  row drive, active-low one-hot; registered.
- key_code  output  4  code of the last accepted key, row*COLS+col; registered.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high while the accepted key is considered down.

## Operation
- Row pointer r runs 0..ROWS-1, and row_out drives row r low.
- Scan step, on each scan_tick:
  - Sample the synchronized columns for row r into the frame accumulator.
  - Then advance r, wrapping ROWS-1 to 0.
- Frame end is the scan_tick taken while r==ROWS-1. At frame end the accumulator is classified:
  - NONE: no column low in any row.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: anything else.
- After classification the accumulator clears. MULTI is treated as NONE for debounce purposes.
- FSM states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE, with a candidate code cand and a counter cnt. Transitions occur only at frame end:
  - IDLE: on SINGLE(c), go to DEB_PRESS with cand=c, cnt=1. If DEBOUNCE==1, go directly to PRESSED instead.
  - DEB_PRESS:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE, go to PRESSED.
    - SINGLE(other): cand=other, cnt=1.
    - NONE: go to IDLE.
  - PRESSED:
    - NONE: go to DEB_RELEASE with cnt=1.
    - SINGLE(other): go to DEB_RELEASE with cnt=1.
    - SINGLE(cand): stay.
  - DEB_RELEASE:
    - NONE: cnt+1. When cnt reaches DEBOUNCE, go to IDLE.
    - SINGLE(cand): go back to PRESSED with no new key_valid.
    - SINGLE(other): go to DEB_PRESS with cand=other, cnt=1.
- On entry to PRESSED from DEB_PRESS or IDLE:
  - key_code is loaded from cand.
  - key_valid pulses.
- key_code holds its value until the next accepted press. Releases never change it.
- key_held is high in PRESSED and DEB_RELEASE, and low otherwise.
- cnt saturates at DEBOUNCE and never wraps.

## Timing
- Reset values:
  - row_out = all ones except bit 0 low (4'b1110), r=0.
  - key_code=0, key_valid=0, key_held=0.
  - FSM in IDLE, cnt=0, accumulator clear.
  - Synchronizer flops cleared to all ones (released).
- Reset is synchronous and overrides everything. A scan_tick coincident with rst is ignored. Reset mid-frame or mid-debounce discards all partial progress.
- Column sample: a scan_tick in cycle t samples the synchronizer output at t. Columns must be stable for at least 2 clocks before t.
- row_out changes at the edge ending cycle t, so it is valid from t+1. Each row therefore settles for about 12000 clocks before it is sampled.
- For a frame-end tick in cycle t:
  - FSM state, key_code, key_held and key_valid all update at the same edge.
  - key_valid is high for exactly cycle t+1.
- Press latency, with the key stable from the start of a frame: key_valid follows the DEBOUNCE-th frame-end tick, i.e. DEBOUNCE*ROWS ticks (16 ms at defaults).
- Release latency: key_held falls DEBOUNCE full NONE frames after the last frame containing the key.
- A scan_tick held high for multiple cycles counts once per cycle. Each cycle is a step; this is not filtered.

## Test plan
- Reset, then 8 ticks with no keys -> row_out sequence 1110, 1101, 1011, 0111, 1110, ...; key_valid, key_held and key_code stay 0.
- Press row 2, col 1 for 6 frames, then release -> one key_valid, one cycle after the 4th frame-end tick; key_code=9. key_held rises with key_valid and falls after the 4th NONE frame.
- Bounce: key 9 present 2 frames, absent 1, present 4 -> exactly one key_valid, after the final run's 4th frame; key_code=9.
- Row 0 col 0 and row 3 col 3 pressed together for 8 frames -> no key_valid; key_held=0; key_code unchanged.
- Key 9 held for 3 frames, then rst for one cycle, key still held -> outputs return to reset values. key_valid arrives only after 4 further complete frames measured from the reset.
- Key 9 accepted, released for 2 frames, then key 5 (row 1, col 1) pressed -> key_held drops when key 5 is first seen. key_valid follows 4 frames of key 5, with key_code=5.
